// File: rtl/data_table_arb_pkg.sv
// Shared types for the data-table arbiter (package hash_table).
// rd_track_t carries addr/fwd/data only when DATA_TABLE_ARB_RAW_FWD_EN is defined.
package hash_table;

    localparam int TABLE_ADDR_WIDTH = 8;
    localparam int DATA_WIDTH       = 8;
    localparam int ENGINE_ID_WIDTH  = 3;

    typedef logic [DATA_WIDTH-1:0]       ram_data_t;
    typedef logic [TABLE_ADDR_WIDTH-1:0] table_addr_t;

    typedef struct packed {
        logic                       valid;
        logic [ENGINE_ID_WIDTH-1:0] id;
`ifdef DATA_TABLE_ARB_RAW_FWD_EN
        table_addr_t                addr;
        logic                       fwd;
        ram_data_t                  data;
`endif
    } rd_track_t;

`ifdef DATA_TABLE_ARB_RAW_FWD_EN
    // A write to the same address as an in-flight read replaces its return data.
    function automatic rd_track_t fwd_merge(input rd_track_t   entry,
                                            input logic        wr_en,
                                            input table_addr_t wr_addr,
                                            input ram_data_t   wr_data);
        rd_track_t merged;
        merged = entry;
        if (entry.valid && wr_en && (wr_addr == entry.addr)) begin
            merged.fwd  = 1'b1;
            merged.data = wr_data;
        end
        return merged;
    endfunction
`endif

endpackage

// File: rtl/data_table_if.sv
// Data table port: one read channel with fixed latency, one write channel.
interface data_table_if;
    import hash_table::*;

    table_addr_t rd_addr;
    logic        rd_en;
    ram_data_t   rd_data;
    table_addr_t wr_addr;
    ram_data_t   wr_data;
    logic        wr_en;

    modport master (output rd_addr, rd_en, wr_addr, wr_data, wr_en, input rd_data);
    modport slave  (input rd_addr, rd_en, wr_addr, wr_data, wr_en, output rd_data);

endinterface

// File: rtl/data_table_arb_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant from req and a registered pointer;
// the pointer moves past the winner whenever advance is high.
module rr_arb #(
    parameter int REQ_CNT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REQ_CNT-1:0] req,
    output logic [REQ_CNT-1:0] ready,
    input  logic               advance
);

    localparam int PW = $clog2(REQ_CNT);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_win;
    logic          w_found;

    // First pass searches from the pointer upward, second pass wraps to index 0.
    always_comb begin
        ready   = '0;
        w_win   = '0;
        w_found = 1'b0;
        if (!rst) begin
            for (int j = 0; j < REQ_CNT; j++) begin
                if (!w_found && req[j] && (PW'(j) >= r_ptr)) begin
                    w_found  = 1'b1;
                    w_win    = PW'(j);
                    ready[j] = 1'b1;
                end
            end
            for (int j = 0; j < REQ_CNT; j++) begin
                if (!w_found && req[j]) begin
                    w_found  = 1'b1;
                    w_win    = PW'(j);
                    ready[j] = 1'b1;
                end
            end
        end
    end

    // NOTE: registered state takes non-blocking assignments; the search above is blocking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (w_win == PW'(REQ_CNT - 1)) ? '0 : w_win + 1'b1;
        end
    end

endmodule

// File: rtl/data_table_arb.sv
// Shares one data table among ENGINES_CNT requesters with independent read/write
// round-robin arbitration. Optional read-after-write forwarding: DATA_TABLE_ARB_RAW_FWD_EN.
module data_table_arb
    import hash_table::*;
#(
    parameter int ENGINES_CNT = 4,
    parameter int A_WIDTH     = TABLE_ADDR_WIDTH,
    parameter int RD_LATENCY  = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ENGINES_CNT-1:0]              rd_req_i,
    input  logic [ENGINES_CNT-1:0][A_WIDTH-1:0] rd_addr_i,
    output logic [ENGINES_CNT-1:0]              rd_ready_o,
    output ram_data_t                           rd_data_o,
    output logic [ENGINES_CNT-1:0]              rd_data_val_o,
    input  logic [ENGINES_CNT-1:0]              wr_req_i,
    input  logic [ENGINES_CNT-1:0][A_WIDTH-1:0] wr_addr_i,
    input  ram_data_t [ENGINES_CNT-1:0]         wr_data_i,
    output logic [ENGINES_CNT-1:0]              wr_ready_o,
    data_table_if.master                        ram
);

    logic                       w_rd_en;
    logic                       w_wr_en;
    logic [A_WIDTH-1:0]         w_rd_addr;
    logic [A_WIDTH-1:0]         w_wr_addr;
    ram_data_t                  w_wr_data;
    logic [ENGINE_ID_WIDTH-1:0] w_rd_id;
    rd_track_t                  w_pipe_raw [RD_LATENCY];
    rd_track_t                  w_pipe_d   [RD_LATENCY];
    rd_track_t                  r_pipe     [RD_LATENCY];
    rd_track_t                  w_ret;

    assign w_rd_en = |(rd_req_i & rd_ready_o);
    assign w_wr_en = |(wr_req_i & wr_ready_o);

    rr_arb #(.REQ_CNT(ENGINES_CNT)) u_rd_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (rd_req_i),
        .ready   (rd_ready_o),
        .advance (w_rd_en)
    );

    rr_arb #(.REQ_CNT(ENGINES_CNT)) u_wr_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (wr_req_i),
        .ready   (wr_ready_o),
        .advance (w_wr_en)
    );

    // Grants are at most one-hot, so the single matching index supplies the fields.
    always_comb begin
        w_rd_addr = '0;
        w_rd_id   = '0;
        w_wr_addr = '0;
        w_wr_data = '0;
        for (int k = 0; k < ENGINES_CNT; k++) begin
            if (rd_ready_o[k]) begin
                w_rd_addr = rd_addr_i[k];
                w_rd_id   = ENGINE_ID_WIDTH'(k);
            end
            if (wr_ready_o[k]) begin
                w_wr_addr = wr_addr_i[k];
                w_wr_data = wr_data_i[k];
            end
        end
    end

    assign ram.rd_en   = w_rd_en;
    assign ram.rd_addr = TABLE_ADDR_WIDTH'(w_rd_addr);
    assign ram.wr_en   = w_wr_en;
    assign ram.wr_addr = TABLE_ADDR_WIDTH'(w_wr_addr);
    assign ram.wr_data = w_wr_data;

    always_comb begin
        w_pipe_raw[0]       = '0;
        w_pipe_raw[0].valid = w_rd_en;
        w_pipe_raw[0].id    = w_rd_id;
`ifdef DATA_TABLE_ARB_RAW_FWD_EN
        w_pipe_raw[0].addr  = TABLE_ADDR_WIDTH'(w_rd_addr);
`endif
        for (int i = 1; i < RD_LATENCY; i++) begin
            w_pipe_raw[i] = r_pipe[i-1];
        end
    end

    // Writes are merged into every stage except the returning one, covering the
    // grant cycle through the cycle before return.
    always_comb begin
        for (int i = 0; i < RD_LATENCY; i++) begin
`ifdef DATA_TABLE_ARB_RAW_FWD_EN
            w_pipe_d[i] = fwd_merge(w_pipe_raw[i], w_wr_en, TABLE_ADDR_WIDTH'(w_wr_addr), w_wr_data);
`else
            w_pipe_d[i] = w_pipe_raw[i];
`endif
        end
    end

    // NOTE: the whole tracking pipeline is reset so a read in flight at reset never strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) r_pipe[i] <= '0;
        end else begin
            for (int i = 0; i < RD_LATENCY; i++) r_pipe[i] <= w_pipe_d[i];
        end
    end

    assign w_ret = r_pipe[RD_LATENCY-1];

    always_comb begin
        rd_data_val_o = '0;
        for (int k = 0; k < ENGINES_CNT; k++) begin
            if (w_ret.valid && (w_ret.id == ENGINE_ID_WIDTH'(k))) rd_data_val_o[k] = 1'b1;
        end
    end

`ifdef DATA_TABLE_ARB_RAW_FWD_EN
    assign rd_data_o = w_ret.fwd ? w_ret.data : ram.rd_data;
`else
    assign rd_data_o = ram.rd_data;
`endif

endmodule

// File: tb/tb_data_table_arb.sv
// Directed bench for data_table_arb with a 2-cycle read-before-write table model.
// Expected forwarding results follow DATA_TABLE_ARB_RAW_FWD_EN.
module tb_data_table_arb;
    import hash_table::*;

    logic                                       clk = 1'b0;
    logic                                       rst;
    logic [3:0]                                 rd_req, rd_ready, rd_val, wr_req, wr_ready;
    logic [3:0][TABLE_ADDR_WIDTH-1:0]           rd_addr, wr_addr;
    ram_data_t [3:0]                            wr_data;
    ram_data_t                                  rd_data;

    int n_vec = 0;
    int n_err = 0;

`ifdef DATA_TABLE_ARB_RAW_FWD_EN
    localparam ram_data_t EXP_SAME  = 8'hAA;
    localparam ram_data_t EXP_AFTER = 8'h55;
`else
    localparam ram_data_t EXP_SAME  = 8'h2C;
    localparam ram_data_t EXP_AFTER = 8'h1C;
`endif

    data_table_if ram_if ();

    data_table_arb #(.ENGINES_CNT(4), .A_WIDTH(TABLE_ADDR_WIDTH), .RD_LATENCY(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_req_i      (rd_req),
        .rd_addr_i     (rd_addr),
        .rd_ready_o    (rd_ready),
        .rd_data_o     (rd_data),
        .rd_data_val_o (rd_val),
        .wr_req_i      (wr_req),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .wr_ready_o    (wr_ready),
        .ram           (ram_if)
    );

    always #5 clk = ~clk;

    // Table model: unwritten locations read as addr ^ 0x3C.
    function automatic ram_data_t init_val(input logic [7:0] a);
        return a ^ 8'h3C;
    endfunction

    function automatic logic [3:0] onehot(input int i);
        return 4'b0001 << i;
    endfunction

    ram_data_t  mem [256];
    logic [255:0] vld;
    ram_data_t  s1, s2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            s1  <= '0;
            s2  <= '0;
        end else begin
            if (ram_if.rd_en)
                s1 <= vld[ram_if.rd_addr] ? mem[ram_if.rd_addr] : init_val(ram_if.rd_addr);
            s2 <= s1;
            if (ram_if.wr_en) begin
                mem[ram_if.wr_addr] <= ram_if.wr_data;
                vld[ram_if.wr_addr] <= 1'b1;
            end
        end
    end

    assign ram_if.rd_data = s2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        rd_req  = 4'hF;
        wr_req  = 4'hF;
        rd_addr = {8'h04, 8'h03, 8'h02, 8'h01};
        wr_addr = {8'h44, 8'h43, 8'h42, 8'h41};
        wr_data = {8'hD4, 8'hD3, 8'hD2, 8'hD1};

        // Outputs held at zero while reset is high, despite active requests.
        #2;
        check("rst_rd_ready", rd_ready, 4'h0);
        check("rst_wr_ready", wr_ready, 4'h0);
        check("rst_rd_val",   rd_val, 4'h0);
        check("rst_rd_en",    ram_if.rd_en, 1'b0);
        check("rst_wr_en",    ram_if.wr_en, 1'b0);
        check("rst_rd_addr",  ram_if.rd_addr, 8'h00);
        check("rst_wr_addr",  ram_if.wr_addr, 8'h00);
        check("rst_wr_data",  ram_if.wr_data, 8'h00);

        @(negedge clk);
        rst    = 1'b0;
        wr_req = 4'h0;

        // Four requesters held: grants rotate 0,1,2,3 and return two cycles later.
        for (int c = 0; c < 10; c++) begin
            rd_req = (c < 8) ? 4'hF : 4'h0;
            #1;
            check("rr4_ready", rd_ready, (c < 8) ? onehot(c % 4) : 4'h0);
            check("rr4_rd_en", ram_if.rd_en, (c < 8));
            if (c < 8) check("rr4_addr", ram_if.rd_addr, 8'(c % 4 + 1));
            check("rr4_val", rd_val, (c >= 2) ? onehot((c - 2) % 4) : 4'h0);
            if (c >= 2) check("rr4_data", rd_data, init_val(8'((c - 2) % 4 + 1)));
            @(negedge clk);
        end

        // Requesters 1 and 3 alternate back to back.
        for (int c = 0; c < 8; c++) begin
            rd_req = (c < 6) ? 4'b1010 : 4'h0;
            #1;
            if (c < 6) begin
                check("alt_ready", rd_ready, (c % 2 == 0) ? 4'b0010 : 4'b1000);
                check("alt_rd_en", ram_if.rd_en, 1'b1);
            end
            check("alt_val", rd_val, (c >= 2) ? ((c % 2 == 0) ? 4'b0010 : 4'b1000) : 4'h0);
            if (c >= 2) check("alt_data", rd_data, init_val((c % 2 == 0) ? 8'h02 : 8'h04));
            @(negedge clk);
        end

        // Same-cycle read (req 2) and write (req 0) to 0x10.
        rd_req     = 4'b0100;
        rd_addr[2] = 8'h10;
        wr_req     = 4'b0001;
        wr_addr[0] = 8'h10;
        wr_data[0] = 8'hAA;
        #1;
        check("raw0_rd_ready", rd_ready, 4'b0100);
        check("raw0_wr_ready", wr_ready, 4'b0001);
        check("raw0_rd_addr",  ram_if.rd_addr, 8'h10);
        check("raw0_wr_en",    ram_if.wr_en, 1'b1);
        check("raw0_wr_addr",  ram_if.wr_addr, 8'h10);
        check("raw0_wr_data",  ram_if.wr_data, 8'hAA);
        @(negedge clk);
        rd_req = 4'h0;
        wr_req = 4'h0;
        #1;
        check("raw0_val_early", rd_val, 4'h0);
        @(negedge clk);
        #1;
        check("raw0_val",  rd_val, 4'b0100);
        check("raw0_data", rd_data, EXP_SAME);

        // Read 0x20 by req 1, then write 0x55 to 0x20 by req 1 one cycle later.
        @(negedge clk);
        rd_req     = 4'b0010;
        rd_addr[1] = 8'h20;
        #1;
        check("raw1_rd_ready", rd_ready, 4'b0010);
        @(negedge clk);
        rd_req     = 4'h0;
        wr_req     = 4'b0010;
        wr_addr[1] = 8'h20;
        wr_data[1] = 8'h55;
        #1;
        check("raw1_wr_ready", wr_ready, 4'b0010);
        check("raw1_val_early", rd_val, 4'h0);
        @(negedge clk);
        wr_req = 4'h0;
        rd_req = 4'b0010;
        #1;
        check("raw1_val",  rd_val, 4'b0010);
        check("raw1_data", rd_data, EXP_AFTER);
        check("raw1_reread_ready", rd_ready, 4'b0010);
        @(negedge clk);
        rd_req = 4'h0;
        #1;
        check("raw1_reread_gap", rd_val, 4'h0);
        @(negedge clk);
        #1;
        check("raw1_reread_val",  rd_val, 4'b0010);
        check("raw1_reread_data", rd_data, 8'h55);

        // Reset one cycle after a read grant drops the read.
        @(negedge clk);
        rd_req     = 4'b0001;
        rd_addr[0] = 8'h05;
        #1;
        check("drop_grant", rd_ready, 4'b0001);
        @(negedge clk);
        rst    = 1'b1;
        wr_req = 4'hF;
        #1;
        check("drop_rd_ready", rd_ready, 4'h0);
        check("drop_wr_ready", wr_ready, 4'h0);
        check("drop_rd_en",    ram_if.rd_en, 1'b0);
        check("drop_wr_en",    ram_if.wr_en, 1'b0);
        check("drop_rd_addr",  ram_if.rd_addr, 8'h00);
        check("drop_wr_addr",  ram_if.wr_addr, 8'h00);
        check("drop_wr_data",  ram_if.wr_data, 8'h00);
        check("drop_val_rst",  rd_val, 4'h0);
        @(negedge clk);
        rst    = 1'b0;
        rd_req = 4'h0;
        wr_req = 4'h0;
        #1;
        check("drop_val_0", rd_val, 4'h0);
        @(negedge clk);
        #1;
        check("drop_val_1", rd_val, 4'h0);

        // First grant after reset goes to the lowest requesting index.
        @(negedge clk);
        rd_req = 4'b0110;
        wr_req = 4'b1100;
        #1;
        check("post_rst_rd", rd_ready, 4'b0010);
        check("post_rst_wr", wr_ready, 4'b0100);
        check("drop_val_2",  rd_val, 4'h0);

        // Single requester on both ports is granted every cycle.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rd_req = 4'b0001;
            wr_req = 4'b0001;
            #1;
            check("solo_rd", rd_ready, 4'b0001);
            check("solo_wr", wr_ready, 4'b0001);
        end

        // Move only the read pointer, then show the two pointers now differ.
        @(negedge clk);
        rd_req = 4'b0011;
        wr_req = 4'h0;
        #1;
        check("indep_rd_only", rd_ready, 4'b0010);
        check("indep_wr_idle", wr_ready, 4'h0);
        @(negedge clk);
        rd_req = 4'b0011;
        wr_req = 4'b0011;
        #1;
        check("indep_rd", rd_ready, 4'b0001);
        check("indep_wr", wr_ready, 4'b0010);
        @(negedge clk);
        rd_req = 4'h0;
        wr_req = 4'h0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_table_arb.md
DATA_TABLE_ARB -- requirements
Module: data_table_arb

Interface
- REQ-001 Parameter ENGINES_CNT, default 4: number of requesters sharing the data table; range 2..8.
- REQ-002 Parameter A_WIDTH, default TABLE_ADDR_WIDTH: table address width.
- REQ-003 Parameter RD_LATENCY, default 2: data table read latency in cycles (rd_en to rd_data); range 1..4.
- REQ-004 clk  input  1: single clock; all logic on its rising edge.
- REQ-005 rst  input  1: reset; asynchronous, active-high.
- REQ-006 rd_req_i  input  ENGINES_CNT: per-requester read request.
- REQ-007 rd_addr_i  input  ENGINES_CNT x A_WIDTH: per-requester read address.
- REQ-008 rd_ready_o  output  ENGINES_CNT: read grant; a read handshake is rd_req_i[k] & rd_ready_o[k].
- REQ-009 rd_data_o  output  ram_data_t: read data, broadcast to all requesters.
- REQ-010 rd_data_val_o  output  ENGINES_CNT: one-cycle strobe marking rd_data_o valid for requester k.
- REQ-011 wr_req_i  input  ENGINES_CNT: per-requester write request.
- REQ-012 wr_addr_i  input  ENGINES_CNT x A_WIDTH: per-requester write address.
- REQ-013 wr_data_i  input  ENGINES_CNT x ram_data_t: per-requester write data.
- REQ-014 wr_ready_o  output  ENGINES_CNT: write grant; a write handshake is wr_req_i[k] & wr_ready_o[k].
- REQ-015 ram  data_table_if.master  -: data table port (rd_addr, rd_en, rd_data, wr_addr, wr_data, wr_en).

Function
- REQ-016 Read and write ports are arbitrated independently, each by its own round-robin pointer.
- REQ-017 Per port, at most one ready bit is high per cycle; it is combinational from the requests and the pointer, and is given to the first requesting index at or after the pointer, with wrap-around.
- REQ-018 The requester must hold req, addr and data stable until its handshake.
- REQ-019 On a handshake by requester k, the pointer becomes (k+1) mod ENGINES_CNT on the next edge; with no handshake the pointer holds.
- REQ-020 ram.rd_en equals |(rd_req_i & rd_ready_o), and ram.rd_addr carries the winner's address in the same cycle.
- REQ-021 ram.wr_en, ram.wr_addr and ram.wr_data carry the write winner's values in the same cycle.
- REQ-022 A RD_LATENCY-deep shift register of {valid, id} tracks each granted read; rd_data_val_o[id] pulses exactly RD_LATENCY cycles after the handshake, and rd_data_o = ram.rd_data.
- REQ-023 Sustained throughput is one read and one write per cycle; no bubbles are inserted.
- REQ-024 With a single requester, that requester is granted every cycle it requests.
- REQ-025 A read and a write to the same address in the same cycle are both granted; data returned depends on REQ-030.

Reset
- REQ-026 While rst is high: all rd_ready_o, wr_ready_o, rd_data_val_o, ram.rd_en and ram.wr_en are 0, and ram addresses and data are 0.
- REQ-027 Reset clears both pointers to 0 and clears all valid bits in the read-tracking pipeline.
- REQ-028 Reads in flight at reset are dropped: no rd_data_val_o strobe is produced for them after reset deasserts.
- REQ-029 The first grant after reset deassertion goes to the lowest-index requester.

Configuration
- REQ-030 Macro DATA_TABLE_ARB_RAW_FWD_EN defined: each pipeline entry also holds its address and a forward flag with data. Any write accepted from the read's grant cycle through the cycle before its return, to the same address, sets the forward flag and loads the write data (latest write wins). On return, rd_data_o uses the forwarded data when the flag is set, otherwise ram.rd_data.
- REQ-031 Macro DATA_TABLE_ARB_RAW_FWD_EN not defined: no forwarding logic is built, and rd_data_o is always ram.rd_data.

Structure
- REQ-032 ram_data_t and TABLE_ADDR_WIDTH come from package hash_table; a new typedef rd_track_t (valid, id, and, when forwarding is compiled in, addr/fwd/data) is added to hash_table.
- REQ-033 One sub-module, rr_arb (parameter REQ_CNT; ports req, ready, advance, clk, rst), is instantiated twice, once for the read port and once for the write port.

Verification
- REQ-034 rd_req_i=4'b1111 held for 8 cycles after reset -> grants 0,1,2,3,0,1,2,3; rd_data_val_o pulses 2 cycles after each grant.
- REQ-035 rd_req_i=4'b1010 held -> grants alternate 1,3,1,3 with no idle cycle, and ram.rd_en stays high.
- REQ-036 Requester 2 reads addr 0x10 and requester 0 writes 0x10 with 0xAA in the same cycle -> forwarding built: requester 2 receives 0xAA; not built: it receives the old data.
- REQ-037 Write 0x55 to addr 0x20 one cycle after a read of 0x20 (RD_LATENCY=2), forwarding built -> the read returns 0x55.
- REQ-038 rst asserted one cycle after a read grant -> outputs 0 immediately, and no rd_data_val_o pulse appears after release.
- REQ-039 wr_req_i=4'b0001 held with rd_req_i=4'b0001 -> requester 0 receives both grants every cycle, and the two pointers move independently.
